// File: rtl/fragment_wb_arbiter_if.sv
// Writeback bus between the execution-unit sources, the register-file write port
// and the stall/flush controls of the fragment writeback arbiter.
interface fragment_wb_arbiter_if #(
  parameter int NUM_SRC  = 4,
  parameter int LANES    = 4,
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 5
);
  logic [NUM_SRC-1:0]                src_valid_i;
  logic [NUM_SRC-1:0]                src_ready_o;
  logic [NUM_SRC*LANES*WIDTH-1:0]    src_data_i;
  logic [NUM_SRC*REG_ADDR-1:0]       src_dest_i;
  logic [NUM_SRC-1:0]                src_bank_i;
  logic [NUM_SRC*LANES-1:0]          src_mask_i;
  logic                              rf_wen_o;
  logic [LANES*WIDTH-1:0]            rf_data_o;
  logic [REG_ADDR-1:0]               rf_dest_o;
  logic                              rf_bank_o;
  logic [LANES-1:0]                  rf_mask_o;
  logic                              stall_i;
  logic                              flush_i;
  logic                              busy_o;

  modport slave (
    input  src_valid_i, src_data_i, src_dest_i, src_bank_i, src_mask_i, stall_i, flush_i,
    output src_ready_o, rf_wen_o, rf_data_o, rf_dest_o, rf_bank_o, rf_mask_o, busy_o
  );

  modport master (
    output src_valid_i, src_data_i, src_dest_i, src_bank_i, src_mask_i, stall_i, flush_i,
    input  src_ready_o, rf_wen_o, rf_data_o, rf_dest_o, rf_bank_o, rf_mask_o, busy_o
  );
endinterface

// File: rtl/fragment_wb_arbiter.sv
// Round-robin writeback arbiter: one holding register per source feeding a single
// registered register-file write port with stall backpressure and flush.
module fragment_wb_arbiter #(
  parameter int NUM_SRC  = 4,
  parameter int LANES    = 4,
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  fragment_wb_arbiter_if.slave bus
);
  localparam int DW    = LANES * WIDTH;
  localparam int PTR_W = $clog2(NUM_SRC);

  typedef struct packed {
    logic [DW-1:0]       data;
    logic [REG_ADDR-1:0] dest;
    logic                bank;
    logic [LANES-1:0]    mask;
  } wb_t;

  wb_t                in_wb [NUM_SRC];
  wb_t                hold  [NUM_SRC];
  wb_t                out_wb;
  logic [NUM_SRC-1:0] hold_v;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] ready;
  logic               out_v;
  logic               advance;
  logic               gany;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gsel;
  logic [PTR_W-1:0]   idx;
  logic [PTR_W-1:0]   rr_next;

  always_comb begin
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      in_wb[s].data = bus.src_data_i[s*DW +: DW];
      in_wb[s].dest = bus.src_dest_i[s*REG_ADDR +: REG_ADDR];
      in_wb[s].bank = bus.src_bank_i[s];
      in_wb[s].mask = bus.src_mask_i[s*LANES +: LANES];
    end
  end

  assign advance = !out_v || !bus.stall_i;

  // Grant uses only held state, never src_valid_i, so ready cannot loop back on valid.
  always_comb begin
    grant = '0;
    gsel  = '0;
    gany  = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      idx = PTR_W'((32'(rr_ptr) + i) % 32'(NUM_SRC));
      if (advance && !gany && hold_v[idx]) begin
        gany = 1'b1;
        gsel = idx;
      end
    end
    if (gany) grant[gsel] = 1'b1;
  end

  always_comb begin
    ready = bus.flush_i ? '0 : (~hold_v | grant);
  end

  assign rr_next = (gsel == PTR_W'(NUM_SRC - 1)) ? '0 : gsel + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_v <= '0;
      out_v  <= 1'b0;
      rr_ptr <= '0;
      out_wb <= '0;
      for (int unsigned s = 0; s < NUM_SRC; s++) hold[s] <= '0;
    end else if (bus.flush_i) begin
      hold_v <= '0;
      out_v  <= 1'b0;
    end else begin
      // A refill of a hold granted this cycle wins over the grant's clear.
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        if (bus.src_valid_i[s] && ready[s]) begin
          hold_v[s] <= |in_wb[s].mask;
          if (|in_wb[s].mask) hold[s] <= in_wb[s];
        end else if (grant[s]) begin
          hold_v[s] <= 1'b0;
        end
      end
      if (advance) begin
        out_v <= gany;
        if (gany) begin
          out_wb <= hold[gsel];
          rr_ptr <= rr_next;
        end
      end
    end
  end

  assign bus.src_ready_o = ready;
  assign bus.rf_wen_o    = out_v;
  assign bus.rf_data_o   = out_wb.data;
  assign bus.rf_dest_o   = out_wb.dest;
  assign bus.rf_bank_o   = out_wb.bank;
  assign bus.rf_mask_o   = out_wb.mask;
  assign bus.busy_o      = out_v || (|hold_v);
endmodule

// File: doc/fragment_wb_arbiter.md
FRAGMENT_WB_ARBITER -- requirements
Module: fragment_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, meaning the number of writeback sources (ALU, FPU, SFU, texture/dcache); legal range 2..8.
REQ-002 SHALL have parameter LANES, default 4, meaning the number of SIMD lanes per writeback.
REQ-003 SHALL have parameter WIDTH, default 32, meaning the bits per lane.
REQ-004 SHALL have parameter REG_ADDR, default 5, meaning the register index width.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port src_valid_i  input  NUM_SRC  per-source writeback request.
REQ-008 SHALL have port src_ready_o  output  NUM_SRC  per-source accept.
REQ-009 SHALL have port src_data_i  input  NUM_SRC*LANES*WIDTH  result; source s occupies slice [s*LANES*WIDTH +: LANES*WIDTH].
REQ-010 SHALL have port src_dest_i  input  NUM_SRC*REG_ADDR  destination register; packed like src_data_i.
REQ-011 SHALL have port src_bank_i  input  NUM_SRC  register bank select.
REQ-012 SHALL have port src_mask_i  input  NUM_SRC*LANES  lane write enables.
REQ-013 SHALL have port rf_wen_o  output  1  register-file write request.
REQ-014 SHALL have ports rf_data_o (LANES*WIDTH), rf_dest_o (REG_ADDR), rf_bank_o (1) and rf_mask_o (LANES), all outputs carrying the write payload.
REQ-015 SHALL have port stall_i  input  1  register file cannot accept this cycle.
REQ-016 SHALL have port flush_i  input  1  discard all pending writebacks.
REQ-017 SHALL have port busy_o  output  1  any entry held or any output pending.

Function
REQ-018 SHALL have one holding register (payload plus hold_v) per source, and one output register (payload plus out_v).
REQ-019 SHALL drive src_ready_o[s] = !flush_i && (!hold_v[s] || grant[s]); grant SHALL NOT depend on src_valid_i, so no combinational loop exists.
REQ-020 SHALL capture source s on a cycle where src_valid_i[s] && src_ready_o[s]; if the mask is all zero, the entry SHALL be dropped and hold_v SHALL NOT be set.
REQ-021 SHALL define advance = !out_v || !stall_i.
REQ-022 SHALL, when advance is high, grant exactly one held source, chosen round-robin: the first hold_v set, searching from pointer rr_ptr upward modulo NUM_SRC.
REQ-023 SHALL, on a grant to s: load the output register from hold s, clear hold_v[s] (unless refilled the same cycle), set out_v, and set rr_ptr = (s+1) mod NUM_SRC.
REQ-024 SHALL, when advance is high and no entry is held, clear out_v.
REQ-025 SHALL hold the output register unchanged and keep rf_wen_o asserted while stall_i is high and out_v is set.
REQ-026 SHALL drive rf_wen_o = out_v; a write commits in any cycle where rf_wen_o && !stall_i.
REQ-027 SHALL give a latency of 2 cycles from accept to rf_wen_o with no contention, and a sustained throughput of one commit per cycle.
REQ-028 SHALL, on a same-cycle refill of a granted hold, load the new payload and keep hold_v[s] set.
REQ-029 SHALL, on flush_i, clear every hold_v and out_v on the next edge; rr_ptr is unchanged and no input is accepted in the flush cycle.
REQ-030 SHALL preserve per-source ordering; ordering across sources is arbitration order only, and hazard checking is the control unit's job.
REQ-031 SHALL drive busy_o = out_v || |hold_v.

Reset
REQ-032 SHALL, on rst low and asynchronously, clear all hold_v, out_v and rr_ptr to 0.
REQ-033 SHALL, during reset, drive rf_wen_o = 0, busy_o = 0 and src_ready_o = all ones; rf_data_o, rf_dest_o, rf_bank_o and rf_mask_o SHALL reset to 0.
REQ-034 SHALL discard any in-flight writeback when reset asserts mid-operation; no partial write SHALL appear after release.
REQ-035 SHALL give the first accept after release at the first rising edge with rst high.

Verification
REQ-036 SHALL cover single source: src 1 valid, dest 7, bank 1, mask 4'b1111, data 0xA..D, accepted at t -> rf_wen_o at t+2 with matching payload, busy_o low at t+3.
REQ-037 SHALL cover contention: all 4 sources valid in the same cycle with rr_ptr = 0 -> commits in order 0, 1, 2, 3 on consecutive cycles, with rr_ptr = 0 afterward.
REQ-038 SHALL cover stall: stall_i high for 3 cycles while out_v is set -> the payload is stable, src_ready_o[s] stays low for sources with held entries, and the write commits on the first cycle stall_i is low.
REQ-039 SHALL cover zero mask: src 2 valid with mask 0 -> src_ready_o high, no rf_wen_o, busy_o stays 0.
REQ-040 SHALL cover flush: 3 entries held plus out_v, flush_i pulsed -> next cycle busy_o = 0, rf_wen_o = 0, and src_valid_i seen in the flush cycle is not accepted.
REQ-041 SHALL cover back-to-back: source 0 streams 8 writebacks, dest 0..7, with no stall -> 8 consecutive rf_wen_o cycles with dest 0..7 in order.
